// File: rtl/id_stage_scoreboard.sv
// Registered ID stage: decodes a 16-bit instruction into S/M/T register indices and memory
// control, tracks in-flight writes in a busy scoreboard and stalls on RAW/WAW hazards.
module id_stage_scoreboard #(
  parameter int REG_W  = 4,
  parameter int IH_IDX = 8,
  parameter int SP_IDX = 9,
  parameter int RA_IDX = 10,
  localparam int NUM_REGS = 2**REG_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [15:0]         instr,
  output logic                in_ready,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [REG_W-1:0]    reg_s,
  output logic [REG_W-1:0]    reg_m,
  output logic [REG_W-1:0]    reg_t,
  output logic                use_s,
  output logic                use_m,
  output logic                wr_t,
  output logic [1:0]          mem_ctrl,
  input  logic                wb_valid,
  input  logic [REG_W-1:0]    wb_reg,
  input  logic                flush,
  output logic [NUM_REGS-1:0] busy_vec
);

  localparam logic [REG_W-1:0] IH = REG_W'(IH_IDX);
  localparam logic [REG_W-1:0] SP = REG_W'(SP_IDX);
  localparam logic [REG_W-1:0] RA = REG_W'(RA_IDX);
  localparam logic [1:0] MEM_LOAD  = 2'b01;
  localparam logic [1:0] MEM_STORE = 2'b10;

  logic [4:0] op, f;
  logic [REG_W-1:0] rx, ry, rz;
  logic [REG_W-1:0] d_s, d_m, d_t;
  logic d_us, d_um, d_wt;
  logic [1:0] d_mem;
  logic [NUM_REGS-1:0] busy, busy_next;
  logic hazard, accept, squash_clear;

  assign op = instr[15:11];
  assign f  = instr[4:0];
  assign rx = REG_W'(instr[10:8]);
  assign ry = REG_W'(instr[7:5]);
  assign rz = REG_W'(instr[4:2]);

  always_comb begin
    d_s = '0; d_m = '0; d_t = '0;
    d_us = 1'b0; d_um = 1'b0; d_wt = 1'b0;
    d_mem = 2'b00;
    case (op)
      5'b00000: begin d_s = SP; d_us = 1'b1; d_t = rx; d_wt = 1'b1; end
      5'b00100, 5'b00101: begin d_s = rx; d_us = 1'b1; end
      5'b00110: begin d_s = ry; d_us = 1'b1; d_t = rx; d_wt = 1'b1; end
      5'b01000: begin d_s = rx; d_us = 1'b1; d_t = ry; d_wt = 1'b1; end
      5'b01001: begin d_s = rx; d_us = 1'b1; d_t = rx; d_wt = 1'b1; end
      5'b01010, 5'b01011, 5'b01110: begin d_s = rx; d_us = 1'b1; end
      5'b01100: begin
        case (instr[10:8])
          3'b010: begin d_s = SP; d_us = 1'b1; d_m = RA; d_um = 1'b1; d_mem = MEM_STORE; end
          3'b011: begin d_s = SP; d_us = 1'b1; d_t = SP; d_wt = 1'b1; end
          3'b100: begin d_s = ry; d_us = 1'b1; d_t = SP; d_wt = 1'b1; end
          default: ;
        endcase
      end
      5'b01101: begin d_t = rx; d_wt = 1'b1; end
      5'b01111: begin d_s = ry; d_us = 1'b1; d_t = rx; d_wt = 1'b1; end
      5'b10010: begin d_s = SP; d_us = 1'b1; d_t = rx; d_wt = 1'b1; d_mem = MEM_LOAD; end
      5'b10011: begin d_s = rx; d_us = 1'b1; d_t = ry; d_wt = 1'b1; d_mem = MEM_LOAD; end
      5'b11010: begin d_s = SP; d_us = 1'b1; d_m = rx; d_um = 1'b1; d_mem = MEM_STORE; end
      5'b11011: begin d_s = ry; d_us = 1'b1; d_m = rx; d_um = 1'b1; d_mem = MEM_STORE; end
      5'b11100: begin d_s = rx; d_us = 1'b1; d_m = ry; d_um = 1'b1; d_t = rz; d_wt = 1'b1; end
      5'b11101: begin
        case (f)
          5'b00000: begin
            case (instr[7:5])
              3'b000: begin d_s = rx; d_us = 1'b1; end
              3'b010: begin d_t = rx; d_wt = 1'b1; end
              3'b110: begin d_s = rx; d_us = 1'b1; d_t = RA; d_wt = 1'b1; end
              default: ;
            endcase
          end
          5'b00010, 5'b00011: begin d_s = rx; d_us = 1'b1; d_m = ry; d_um = 1'b1; end
          5'b01010: begin d_s = ry; d_us = 1'b1; d_m = rx; d_um = 1'b1; end
          5'b00100, 5'b00110, 5'b00111: begin
            d_s = ry; d_us = 1'b1; d_m = rx; d_um = 1'b1; d_t = ry; d_wt = 1'b1;
          end
          5'b01100, 5'b01101, 5'b01110: begin
            d_s = ry; d_us = 1'b1; d_m = rx; d_um = 1'b1; d_t = rx; d_wt = 1'b1;
          end
          5'b01011, 5'b01111: begin d_s = ry; d_us = 1'b1; d_t = rx; d_wt = 1'b1; end
          default: ;
        endcase
      end
      5'b11110: begin
        if (instr[0]) begin d_s = rx; d_us = 1'b1; d_t = IH; d_wt = 1'b1; end
        else          begin d_s = IH; d_us = 1'b1; d_t = rx; d_wt = 1'b1; end
      end
      default: ;
    endcase
  end

  assign hazard = in_valid & ((d_us & busy[d_s]) | (d_um & busy[d_m]) | (d_wt & busy[d_t]));
  assign in_ready = ~rst & ~flush & ~hazard & (~out_valid | out_ready);
  assign accept = in_valid & in_ready;

  // A squashed writer frees its T, but only while the single clear port is not claimed by
  // a writeback to some other register.
  assign squash_clear = flush & out_valid & ~out_ready & wr_t & ~(wb_valid & (wb_reg != reg_t));

  always_comb begin
    busy_next = busy;
    if (wb_valid) busy_next[wb_reg] = 1'b0;
    if (squash_clear) busy_next[reg_t] = 1'b0;
    if (accept && d_wt) busy_next[d_t] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy      <= '0;
      out_valid <= 1'b0;
      reg_s     <= '0;
      reg_m     <= '0;
      reg_t     <= '0;
      use_s     <= 1'b0;
      use_m     <= 1'b0;
      wr_t      <= 1'b0;
      mem_ctrl  <= 2'b00;
    end else begin
      busy <= busy_next;
      if (accept) begin
        out_valid <= 1'b1;
        reg_s     <= d_s;
        reg_m     <= d_m;
        reg_t     <= d_t;
        use_s     <= d_us;
        use_m     <= d_um;
        wr_t      <= d_wt;
        mem_ctrl  <= d_mem;
      end else if (flush || out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign busy_vec = busy;

endmodule
